// File: rtl/minesweeper_cursor_ctrl.sv
// Cursor and reveal/flag command issuer for the minesweeper board engine.
// Optional macro CURSOR_WRAP_EN: cursor wraps at board edges instead of saturating.
module minesweeper_cursor_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MV_UP,
  input  logic          MV_DN,
  input  logic          MV_LF,
  input  logic          MV_RT,
  input  logic          REVEAL,
  input  logic          FLAG,
  input  logic          LOCK,
  output logic [RW-1:0] CUR_ROW,
  output logic [CW-1:0] CUR_COL,
  output logic          CMD_VALID,
  output logic          CMD_TYPE,
  output logic [RW-1:0] CMD_ROW,
  output logic [CW-1:0] CMD_COL,
  input  logic          CMD_READY,
  output logic          BUSY,
  output logic          DROP
);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          cmd_typ_q, cmd_typ_d;
  logic [RW-1:0] cmd_row_q, cmd_row_d;
  logic [CW-1:0] cmd_col_q, cmd_col_d;
  logic          pend_v_q, pend_v_d;
  logic          pend_typ_q, pend_typ_d;
  logic [RW-1:0] pend_row_q, pend_row_d;
  logic [CW-1:0] pend_col_q, pend_col_d;
  logic          lock_q;
  logic          drop_q, drop_d;

  logic up, dn, lf, rt, cap, cap_typ, hs, pend_eff;

  always_comb begin
    up       = MV_UP & ~LOCK;
    dn       = MV_DN & ~LOCK;
    lf       = MV_LF & ~LOCK;
    rt       = MV_RT & ~LOCK;
    cap      = ~LOCK & (REVEAL | FLAG);
    cap_typ  = ~REVEAL;
    hs       = (state_q == ISSUE) & CMD_READY;
    // Rising LOCK empties the slot before this cycle's handshake can consume it.
    pend_eff = pend_v_q & ~(LOCK & ~lock_q);

    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cmd_typ_d  = cmd_typ_q;
    cmd_row_d  = cmd_row_q;
    cmd_col_d  = cmd_col_q;
    pend_v_d   = pend_eff;
    pend_typ_d = pend_typ_q;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    drop_d     = ~LOCK & REVEAL & FLAG;

    if (up && !dn) begin
      if (row_q == '0) row_d = WRAP ? ROW_MAX : row_q;
      else             row_d = row_q - RW'(1);
    end else if (dn && !up) begin
      if (row_q == ROW_MAX) row_d = WRAP ? '0 : row_q;
      else                  row_d = row_q + RW'(1);
    end

    if (lf && !rt) begin
      if (col_q == '0) col_d = WRAP ? COL_MAX : col_q;
      else             col_d = col_q - CW'(1);
    end else if (rt && !lf) begin
      if (col_q == COL_MAX) col_d = WRAP ? '0 : col_q;
      else                  col_d = col_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d   = ISSUE;
          cmd_typ_d = cap_typ;
          cmd_row_d = row_q;
          cmd_col_d = col_q;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (pend_eff) begin
            cmd_typ_d = pend_typ_q;
            cmd_row_d = pend_row_q;
            cmd_col_d = pend_col_q;
            pend_v_d  = cap;
            if (cap) begin
              pend_typ_d = cap_typ;
              pend_row_d = row_q;
              pend_col_d = col_q;
            end
          end else if (cap) begin
            cmd_typ_d = cap_typ;
            cmd_row_d = row_q;
            cmd_col_d = col_q;
          end else begin
            state_d = IDLE;
          end
        end else if (cap) begin
          if (!pend_eff) begin
            pend_v_d   = 1'b1;
            pend_typ_d = cap_typ;
            pend_row_d = row_q;
            pend_col_d = col_q;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cmd_typ_q  <= 1'b0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      pend_v_q   <= 1'b0;
      pend_typ_q <= 1'b0;
      pend_row_q <= '0;
      pend_col_q <= '0;
      lock_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cmd_typ_q  <= cmd_typ_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
      pend_v_q   <= pend_v_d;
      pend_typ_q <= pend_typ_d;
      pend_row_q <= pend_row_d;
      pend_col_q <= pend_col_d;
      lock_q     <= LOCK;
      drop_q     <= drop_d;
    end
  end

  assign CUR_ROW   = row_q;
  assign CUR_COL   = col_q;
  assign CMD_VALID = (state_q == ISSUE);
  assign CMD_TYPE  = cmd_typ_q;
  assign CMD_ROW   = cmd_row_q;
  assign CMD_COL   = cmd_col_q;
  assign BUSY      = (state_q == ISSUE) | pend_v_q;
  assign DROP      = drop_q;

endmodule

// File: tb/tb_minesweeper_cursor_ctrl.sv
// Directed vector bench for minesweeper_cursor_ctrl (8x8 board).
module tb_minesweeper_cursor_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, MV_UP, MV_DN, MV_LF, MV_RT, REVEAL, FLAG, LOCK, CMD_READY;
  logic [2:0] CUR_ROW, CUR_COL, CMD_ROW, CMD_COL;
  logic       CMD_VALID, CMD_TYPE, BUSY, DROP;

  minesweeper_cursor_ctrl #(.ROWS(8), .COLS(8), .RW(3), .CW(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .MV_UP(MV_UP), .MV_DN(MV_DN), .MV_LF(MV_LF), .MV_RT(MV_RT),
    .REVEAL(REVEAL), .FLAG(FLAG), .LOCK(LOCK),
    .CUR_ROW(CUR_ROW), .CUR_COL(CUR_COL),
    .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .CMD_ROW(CMD_ROW), .CMD_COL(CMD_COL),
    .CMD_READY(CMD_READY), .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  localparam logic [8:0] NONE = 9'h000, RST = 9'h100, UP = 9'h080, DN = 9'h040,
                         LF = 9'h020, RT = 9'h010, REV = 9'h008, FLG = 9'h004,
                         LCK = 9'h002, RDY = 9'h001;

  // exp layout: row[15:13] col[12:10] valid[9] type[8] crow[7:5] ccol[4:2] busy[1] drop[0]
  typedef struct packed {
    logic [8:0]  in;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   npass = 0;
  int   ntotal = 0;

  task automatic add(input logic [8:0] in, input int r, input int c, input logic val,
                     input logic typ, input int cr, input int cc, input logic busy,
                     input logic drop);
    vec_t v;
    v.in  = in;
    v.exp = {3'(r), 3'(c), val, typ, 3'(cr), 3'(cc), busy, drop};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [8:0] in);
    {RESET, MV_UP, MV_DN, MV_LF, MV_RT, REVEAL, FLAG, LOCK, CMD_READY} = in;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [15:0] outs();
    return {CUR_ROW, CUR_COL, CMD_VALID, CMD_TYPE, CMD_ROW, CMD_COL, BUSY, DROP};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask, snap;
    bit seen;
    drive(RST);

    add(RST,       0,0, 0,0,0,0, 0,0);
    add(RT,        0,1, 0,0,0,0, 0,0);
    add(NONE,      0,1, 0,0,0,0, 0,0);
    add(RT,        0,2, 0,0,0,0, 0,0);
    add(RT,        0,3, 0,0,0,0, 0,0);
    add(DN,        1,3, 0,0,0,0, 0,0);
    add(DN,        2,3, 0,0,0,0, 0,0);
    add(REV,       2,3, 1,0,2,3, 1,0);
    add(RT,        2,4, 1,0,2,3, 1,0);
    add(FLG,       2,4, 1,0,2,3, 1,0);
    add(REV,       2,4, 1,0,2,3, 1,1);
    add(NONE,      2,4, 1,0,2,3, 1,0);
    add(RDY,       2,4, 1,1,2,4, 1,0);
    add(RDY,       2,4, 0,0,0,0, 0,0);
    add(RDY,       2,4, 0,0,0,0, 0,0);
    add(DN|LF,     3,3, 0,0,0,0, 0,0);
    add(DN|LF,     4,2, 0,0,0,0, 0,0);
    add(DN|LF,     5,1, 0,0,0,0, 0,0);
    add(REV|FLG,   5,1, 1,0,5,1, 1,1);
    add(NONE,      5,1, 1,0,5,1, 1,0);
    add(UP|DN|RT,  5,2, 1,0,5,1, 1,0);
    add(LF|RT,     5,2, 1,0,5,1, 1,0);
    add(RDY,       5,2, 0,0,0,0, 0,0);
    add(REV,       5,2, 1,0,5,2, 1,0);
    add(FLG|RDY,   5,2, 1,1,5,2, 1,0);
    add(FLG,       5,2, 1,1,5,2, 1,0);
    add(REV|RDY,   5,2, 1,1,5,2, 1,0);
    add(RDY,       5,2, 1,0,5,2, 1,0);
    add(RDY,       5,2, 0,0,0,0, 0,0);
    add(REV,       5,2, 1,0,5,2, 1,0);
    add(FLG,       5,2, 1,0,5,2, 1,0);
    add(LCK,       5,2, 1,0,5,2, 1,0);
    add(LCK|REV|RT,5,2, 1,0,5,2, 1,0);
    add(LCK|RDY,   5,2, 0,0,0,0, 0,0);
    add(LCK|REV|UP,5,2, 0,0,0,0, 0,0);
    add(NONE,      5,2, 0,0,0,0, 0,0);
    add(REV,       5,2, 1,0,5,2, 1,0);
    add(RST|REV,   0,0, 0,0,0,0, 0,0);
`ifdef CURSOR_WRAP_EN
    add(UP|LF,     7,7, 0,0,0,0, 0,0);
`else
    add(UP|LF,     0,0, 0,0,0,0, 0,0);
`endif
    add(RST,       0,0, 0,0,0,0, 0,0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].in);
      @(posedge CLK);
      #1;
      mask = vecs[i].exp[9] ? 16'hFFFF : 16'hFE03;
      chk($sformatf("vec%0d", i), outs() & mask, vecs[i].exp & mask);
    end

    // Hand sequence: bounded wait for a fresh command, then hold it with READY low.
    @(negedge CLK); drive(REV);
    @(negedge CLK); drive(NONE);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (CMD_VALID === 1'b1) seen = 1'b1;
      else @(negedge CLK);
    end
    chk("cmd_valid_wait", {15'd0, seen}, 16'd1);
    snap = 16'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("hold%0d", k), {8'd0, CMD_VALID, CMD_TYPE, CMD_ROW, CMD_COL},
          {8'd0, 1'b1, 1'b0, 3'd0, 3'd0});
    end
    drive(RDY);
    @(posedge CLK); #1;
    drive(NONE);
    chk("release", {14'd0, CMD_VALID, BUSY}, 16'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/minesweeper_cursor_ctrl.md
Name: minesweeper_cursor_ctrl

Overview:
- Consumes the single-cycle enable pulses produced by the per-button debouncers: MCEN-style move enables from four direction buttons, and SCEN-style enables from the reveal and flag buttons.
- Maintains the board cursor and issues reveal/flag commands to the board engine over a valid/ready handshake.
- Has a one-deep pending slot so a button press made while a command is outstanding is not lost.

Parameters:
- ROWS, 8, number of board rows (cursor row range 0..ROWS-1).
- COLS, 8, number of board columns (cursor column range 0..COLS-1).
- RW, 3, width of row fields; must be at least clog2(ROWS).
- CW, 3, width of column fields; must be at least clog2(COLS).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MV_UP  in  1  single-cycle move enable from the debouncer; row -1.
- MV_DN  in  1  single-cycle move enable; row +1.
- MV_LF  in  1  single-cycle move enable; column -1.
- MV_RT  in  1  single-cycle move enable; column +1.
- REVEAL  in  1  single-cycle enable from the centre button.
- FLAG  in  1  single-cycle enable from the flag button.
- LOCK  in  1  game over/won; new moves and commands are ignored while high.
- CUR_ROW  out  RW  current cursor row.
- CUR_COL  out  CW  current cursor column.
- CMD_VALID  out  1  a command is presented.
- CMD_TYPE  out  1  0 = reveal, 1 = toggle flag.
- CMD_ROW  out  RW  target row of the presented command.
- CMD_COL  out  CW  target column of the presented command.
- CMD_READY  in  1  board engine accepts the command.
- BUSY  out  1  CMD_VALID high or pending slot full.
- DROP  out  1  one-cycle pulse when a command is discarded.

Behaviour:
- Reset (synchronous, active-high; takes priority over all other inputs):
  - CUR_ROW = 0, CUR_COL = 0.
  - CMD_VALID = 0, CMD_TYPE = 0, CMD_ROW = 0, CMD_COL = 0.
  - Pending slot empty, BUSY = 0, DROP = 0, FSM in IDLE.
  - A reset asserted mid-handshake drops the outstanding command without waiting for CMD_READY.
- Cursor:
  - A move pulse in cycle n updates the cursor in cycle n+1.
  - MV_UP together with MV_DN cancels (no row change); MV_LF together with MV_RT cancels (no column change).
  - One vertical and one horizontal move in the same cycle are both applied (diagonal step).
  - Boundary: see the Optional Feature section.
  - Moves are accepted regardless of handshake state, except while LOCK is high.
- Command capture:
  - REVEAL or FLAG in cycle n captures {type, CUR_ROW, CUR_COL} using the cursor value in cycle n, before any move taken in the same cycle.
  - REVEAL and FLAG in the same cycle: reveal wins, flag is discarded, DROP pulses.
- FSM states:
  - IDLE: CMD_VALID = 0. A capture moves to ISSUE, with CMD_VALID = 1 in cycle n+1.
  - ISSUE: CMD_VALID = 1. CMD_TYPE, CMD_ROW and CMD_COL stay stable until CMD_VALID && CMD_READY.
  - On handshake with the pending slot full: the pending command is loaded onto the outputs, CMD_VALID stays 1 (back-to-back), and the slot empties.
  - On handshake with the slot empty and a capture in the same cycle: the new command is presented directly next cycle and the FSM stays in ISSUE.
  - On handshake otherwise: return to IDLE.
- Pending slot:
  - A capture in ISSUE without a handshake fills the pending slot if it is empty.
  - If the slot is already full, the new capture is discarded and DROP pulses for 1 cycle.
  - A capture in the same cycle as a handshake while the slot is full: the pending command goes to the outputs and the new capture enters the slot.
- LOCK:
  - Moves and captures are ignored, with no DROP pulse.
  - The rising edge of LOCK clears the pending slot.
  - A command already presented still completes its handshake.
- CMD_READY while CMD_VALID = 0 is ignored.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moves wrap around the board edges (row 0 up -> ROWS-1, ROWS-1 down -> 0; the same for columns with COLS).
- Undefined: moves saturate at the edges; a move off the board leaves that coordinate unchanged.

Test Plan:
- Reset, then MV_RT x3 and MV_DN x2 single pulses -> CUR_COL = 3, CUR_ROW = 2; each coordinate updates 1 cycle after its pulse.
- At (0,0), MV_UP and MV_LF:
  - without CURSOR_WRAP_EN -> cursor stays (0,0);
  - with it -> (7,7).
- CMD_READY held 0. REVEAL at (2,3), then MV_RT, then FLAG, then REVEAL:
  - CMD = {0,2,3} held stable;
  - pending slot holds {1,2,4};
  - the third command is discarded and DROP pulses once;
  - then raise CMD_READY -> {0,2,3} accepted, then {1,2,4} presented the next cycle, then IDLE.
- REVEAL and FLAG in the same cycle at (5,1) -> only CMD = {0,5,1} is presented and DROP pulses once.
- Command pending, then LOCK=1 -> the presented command still completes on CMD_READY, the pending command is cleared, and later REVEAL and move pulses are ignored.
- RESET asserted while CMD_VALID = 1 -> next cycle CMD_VALID = 0, cursor (0,0), BUSY = 0.
